// File: rtl/hyper_tape_pkg.sv
// Shared definitions for the HYPERLOAD/HYPERSAVE byte port: register map,
// status/control bit positions and the bus-handshake state encoding.
package hyper_tape_pkg;

  localparam logic [7:0] REG_DATA   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;
  localparam logic [7:0] REG_CTRL   = 8'd2;

  localparam int ST_RXNE  = 0;
  localparam int ST_TXNF  = 1;
  localparam int ST_EOF   = 2;
  localparam int ST_UNDER = 3;
  localparam int ST_OVER  = 4;
  localparam int ST_OVR   = 7;

  localparam int CT_LOAD  = 0;
  localparam int CT_SAVE  = 1;
  localparam int CT_FLUSH = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACT  = 2'd1,
    S_HOLD = 2'd2
  } bus_state_e;

endpackage

// File: rtl/hyper_tape_port_byte_fifo.sv
// First-word-fall-through byte FIFO; head is the oldest entry whenever not empty.
// Flush empties it and takes priority over a push or pop in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hyper_tape_port.sv
// Z80 I/O port moving whole bytes between the patched tape ROM routines and a host stream.
// Save path (TX FIFO, req_save, OVERRUN) is built only when HYPER_TAPE_SAVE_EN is defined.
module hyper_tape_port
  import hyper_tape_pkg::*;
#(
  parameter logic [7:0] PORT_BASE  = 8'hE0,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       override,
  input  logic [7:0] a,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_eof,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       req_load,
  output logic       req_save
);

  logic [7:0] w_off;
  logic       w_hit, w_rd, w_wr, w_act, w_fire;
  logic       r_act_prev, r_rd_op, r_run;
  bus_state_e r_state, w_state_next;

  assign w_off  = a - PORT_BASE;
  assign w_hit  = override & ~iorq_n & (w_off < 8'd3);
  assign w_rd   = w_hit & ~rd_n;
  assign w_wr   = w_hit & ~wr_n & rd_n;
  assign w_act  = w_rd | w_wr;
  // One action per strobe: only the rising edge of the decoded access counts.
  assign w_fire = w_act & ~r_act_prev & (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_act_prev <= 1'b0;
      r_rd_op    <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_act_prev <= w_act;
      r_run      <= 1'b1;
      if (w_fire) r_rd_op <= w_rd;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fire) w_state_next = S_ACT;
      S_ACT:   w_state_next = S_HOLD;
      S_HOLD:  if (iorq_n) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign d_oe = r_rd_op & (r_state != S_IDLE);

  logic w_data_rd, w_data_wr, w_ctrl_wr, w_load, w_flush;

  assign w_data_rd = w_fire & w_rd & (w_off == REG_DATA);
  assign w_data_wr = w_fire & w_wr & (w_off == REG_DATA);
  assign w_ctrl_wr = w_fire & w_wr & (w_off == REG_CTRL);
  assign w_load    = w_ctrl_wr & d_in[CT_LOAD];
  assign w_flush   = w_ctrl_wr & d_in[CT_FLUSH];

  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0] w_rx_head;

  // r_run keeps the host from pushing while reset is still applied.
  assign in_ready  = override & r_run & ~w_rx_full;
  assign w_rx_push = in_valid & in_ready;
  assign w_rx_pop  = w_data_rd & ~w_rx_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .flush (w_load | w_flush),
    .wdata (in_data),
    .head  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  logic w_txnf, w_over;

`ifdef HYPER_TAPE_SAVE_EN
  logic       w_tx_full, w_tx_empty, w_save;
  logic [7:0] w_tx_head;
  logic       r_over, r_req_save;

  assign w_save = w_ctrl_wr & d_in[CT_SAVE];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_data_wr),
    .pop   (out_valid & out_ready),
    .flush (w_save | w_flush),
    .wdata (d_in),
    .head  (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_over     <= 1'b0;
      r_req_save <= 1'b0;
    end else begin
      r_req_save <= w_save;
      if (w_save) r_over <= 1'b0;
      else if (w_data_wr & w_tx_full) r_over <= 1'b1;
    end
  end

  assign out_valid = ~w_tx_empty;
  assign out_data  = w_tx_empty ? 8'h00 : w_tx_head;
  assign req_save  = r_req_save;
  assign w_txnf    = ~w_tx_full;
  assign w_over    = r_over;
`else
  logic w_unused;

  assign w_unused  = &{1'b0, out_ready, d_in[7:3], d_in[1], w_data_wr};
  assign out_valid = 1'b0;
  assign out_data  = 8'h00;
  assign req_save  = 1'b0;
  assign w_txnf    = 1'b0;
  assign w_over    = 1'b0;
`endif

  logic [7:0] w_status;
  logic [7:0] r_dout;
  logic       r_eof, r_under, r_req_load;

  always_comb begin
    w_status           = 8'h00;
    w_status[ST_RXNE]  = ~w_rx_empty;
    w_status[ST_TXNF]  = w_txnf;
    w_status[ST_EOF]   = r_eof & w_rx_empty;
    w_status[ST_UNDER] = r_under;
    w_status[ST_OVER]  = w_over;
    w_status[ST_OVR]   = override;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout     <= 8'h00;
      r_eof      <= 1'b0;
      r_under    <= 1'b0;
      r_req_load <= 1'b0;
    end else begin
      r_req_load <= w_load;
      if (w_load) r_eof <= 1'b0;
      else if (in_eof) r_eof <= 1'b1;
      if (w_load) r_under <= 1'b0;
      else if (w_data_rd & w_rx_empty) r_under <= 1'b1;
      if (w_fire & w_rd) begin
        case (w_off)
          REG_DATA:   r_dout <= w_rx_empty ? 8'hFF : w_rx_head;
          REG_STATUS: r_dout <= w_status;
          default:    r_dout <= 8'h00;
        endcase
      end
    end
  end

  assign d_out    = r_dout;
  assign req_load = r_req_load;

endmodule

// File: tb/tb_hyper_tape_port.sv
// Bench for hyper_tape_port: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_hyper_tape_port;

  localparam logic [7:0] BASE = 8'hE0;
  localparam int D = 16;
`ifdef HYPER_TAPE_SAVE_EN
  localparam bit SAVE = 1'b1;
`else
  localparam bit SAVE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       override, iorq_n, rd_n, wr_n, in_valid, in_eof, out_ready;
  logic [7:0] a, d_in, in_data;
  wire  [7:0] d_out, out_data;
  wire        d_oe, in_ready, out_valid, req_load, req_save;

  always #5 clk = ~clk;

  hyper_tape_port #(.PORT_BASE(BASE), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .override(override), .a(a), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_eof(in_eof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .req_load(req_load), .req_save(req_save)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_rl = 0;
  bit chk_en = 0;
  bit rand_host = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] m_dout;
  bit m_eof, m_under, m_over, m_req_load, m_req_save;
  bit m_busy, m_phase, m_rd, m_prev, m_run;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    m_status = {override, 2'b00, SAVE & m_over, m_under, m_eof & (rxq.size() == 0),
                SAVE & (txq.size() < D), rxq.size() != 0};
  endfunction

  task automatic model_reset();
    rxq.delete(); txq.delete();
    m_dout = 8'h00;
    m_eof = 0; m_under = 0; m_over = 0; m_req_load = 0; m_req_save = 0;
    m_busy = 0; m_phase = 0; m_rd = 0; m_prev = 0; m_run = 0;
  endtask

  task automatic model_update();
    logic [7:0] off, st;
    bit act, fire, rdop, inr, cpu_pop, cpu_push, load, save, flush, hpush, hpop;
    int rx_n, tx_n;
    rx_n = rxq.size(); tx_n = txq.size(); st = m_status();
    off  = a - BASE;
    act  = override && !iorq_n && (!rd_n || !wr_n) && (off < 8'd3);
    rdop = !rd_n;
    fire = act && !m_prev && !m_busy;
    inr  = override && m_run && (rx_n < D);
    cpu_pop = 0; cpu_push = 0; load = 0; save = 0; flush = 0;
    if (fire && rdop) begin
      if (off == 8'd0) begin
        if (rx_n > 0) begin m_dout = rxq[0]; cpu_pop = 1; end
        else begin m_dout = 8'hFF; m_under = 1; end
      end else if (off == 8'd1) m_dout = st;
      else m_dout = 8'h00;
    end else if (fire) begin
      if (off == 8'd0) begin
        if (SAVE && tx_n < D) cpu_push = 1;
        else if (SAVE) m_over = 1;
      end else if (off == 8'd2) begin
        load = d_in[0]; save = SAVE && d_in[1]; flush = d_in[2];
      end
    end
    hpush = in_valid && inr;
    hpop  = SAVE && (tx_n > 0) && out_ready;
    if (load || flush) rxq.delete();
    else begin
      if (cpu_pop) void'(rxq.pop_front());
      if (hpush) rxq.push_back(in_data);
    end
    if (save || flush) txq.delete();
    else begin
      if (hpop) void'(txq.pop_front());
      if (cpu_push) txq.push_back(d_in);
    end
    if (load) begin m_eof = 0; m_under = 0; end
    else if (in_eof) m_eof = 1;
    if (save) m_over = 0;
    m_req_load = load; m_req_save = save;
    if (fire) begin m_busy = 1; m_phase = 0; m_rd = rdop; end
    else if (m_busy) begin
      if (!m_phase) m_phase = 1;
      else if (iorq_n) m_busy = 0;
    end
    m_prev = act; m_run = 1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 8'(override & m_run & (rxq.size() < D)), 8'(in_ready));
      check("out_valid", 8'(out_valid), 8'(SAVE && txq.size() > 0));
      check("out_data", out_data, (SAVE && txq.size() > 0) ? txq[0] : 8'h00);
      check("req_load", 8'(req_load), 8'(m_req_load));
      check("req_save", 8'(req_save), 8'(m_req_save));
      check("d_oe", 8'(d_oe), 8'(m_busy && m_rd));
      check("d_out", d_out, m_dout);
      if (req_load) n_rl++;
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    @(negedge clk);
    #1;
    if (rand_host) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_eof    = ($urandom_range(0, 60) == 0);
      if (!override && $urandom_range(0, 7) == 0) override = 1'b1;
      else if (override && $urandom_range(0, 150) == 0) override = 1'b0;
    end
  endtask

  task automatic cpu_access(input bit rd, input logic [1:0] off, input logic [7:0] wd,
                            input int hold, output logic [7:0] rdv);
    a = BASE + {6'b0, off}; d_in = wd; iorq_n = 1'b0;
    if (rd) rd_n = 1'b0; else wr_n = 1'b0;
    step();
    rdv = d_out;
    repeat (hold - 1) step();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    step(); step();
    $display("cpu %s off=%0d wdata=%02h rdata=%02h ovr=%0d", rd ? "rd" : "wr", off, wd, rdv, override);
  endtask

  task automatic host_push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    step();
    in_valid = 1'b0;
    $display("host push %02h", b);
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    #1;
    check("rst_d_out", d_out, 8'h00);
    check("rst_d_oe", 8'(d_oe), 8'h00);
    check("rst_in_ready", 8'(in_ready), 8'h00);
    check("rst_out_valid", 8'(out_valid), 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_req_load", 8'(req_load), 8'h00);
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] got[$];
    int rl0;
    override = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 8'h00; d_in = 8'h00; in_valid = 1'b0; in_data = 8'h00; in_eof = 1'b0; out_ready = 1'b0;
    model_reset();
    chk_en = 1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Status after reset
    cpu_access(1, 2'd1, 8'h00, 2, r);
    check("reset_status", r, SAVE ? 8'h82 : 8'h80);
    check("no_req_load", 8'(n_rl), 8'h00);

    // Two pushed bytes, then an underrun
    host_push(8'h3A); host_push(8'hC5);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("rd_first", r, 8'h3A);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("rd_second", r, 8'hC5);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("rd_empty", r, 8'hFF);
    cpu_access(1, 2'd1, 8'h00, 2, r); check("under_bit", 8'(r[3]), 8'h01);

    // Fill RX, then free one slot
    for (int i = 0; i < D; i++) host_push(8'h10 + 8'(i));
    check("in_ready_full", 8'(in_ready), 8'h00);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("rd_after_full", r, 8'h10);
    check("in_ready_freed", 8'(in_ready), 8'h01);
    cpu_access(0, 2'd2, 8'h04, 2, r);
    cpu_access(1, 2'd1, 8'h00, 2, r); check("flush_rxne", 8'(r[0]), 8'h00);

    // EOF visible only once RX drains; start-load clears it
    host_push(8'h7E);
    in_eof = 1'b1; step(); in_eof = 1'b0;
    cpu_access(1, 2'd1, 8'h00, 2, r); check("eof_with_data", 8'(r[2]), 8'h00);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("rd_eof_byte", r, 8'h7E);
    cpu_access(1, 2'd1, 8'h00, 2, r); check("eof_empty", 8'(r[2]), 8'h01);
    rl0 = n_rl;
    cpu_access(0, 2'd2, 8'h01, 2, r);
    cpu_access(1, 2'd1, 8'h00, 2, r);
    check("eof_cleared", 8'(r[2]), 8'h00);
    check("under_cleared", 8'(r[3]), 8'h00);
    check("req_load_pulses", 8'(n_rl - rl0), 8'h01);

    // Save path: overflow then drain
    out_ready = 1'b0;
    cpu_access(0, 2'd0, 8'h55, 2, r);
    check("tx_valid", 8'(out_valid), 8'(SAVE));
    check("tx_head", out_data, SAVE ? 8'h55 : 8'h00);
    for (int i = 1; i <= D; i++) cpu_access(0, 2'd0, 8'(i), 1, r);
    cpu_access(1, 2'd1, 8'h00, 2, r); check("over_bit", 8'(r[4]), 8'(SAVE));
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) got.push_back(out_data);
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 8'(got.size()), SAVE ? 8'd16 : 8'd0);
    for (int i = 0; i < got.size(); i++) check("drain_byte", got[i], (i == 0) ? 8'h55 : 8'(i));
    cpu_access(0, 2'd2, 8'h02, 2, r);

    // Long strobe pops exactly once
    host_push(8'hAA); host_push(8'hBB);
    cpu_access(1, 2'd0, 8'h00, 5, r); check("long_strobe", r, 8'hAA);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("after_long", r, 8'hBB);
    cpu_access(1, 2'd0, 8'h00, 2, r); check("after_long_empty", r, 8'hFF);

    // Override low: no host ready, no decode
    override = 1'b0; step();
    check("ovr_in_ready", 8'(in_ready), 8'h00);
    cpu_access(1, 2'd1, 8'h00, 2, r); check("ovr_no_decode", r, 8'hFF);
    override = 1'b1; step();

    // Asynchronous reset mid-transfer
    host_push(8'h01); host_push(8'h02); host_push(8'h03);
    a = BASE; iorq_n = 1'b0; rd_n = 1'b0; step();
    do_reset();
    cpu_access(1, 2'd1, 8'h00, 2, r);
    check("post_reset_status", r, SAVE ? 8'h82 : 8'h80);

    // Randomized traffic
    rand_host = 1;
    repeat (250) begin
      repeat ($urandom_range(0, 3)) step();
      cpu_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 int'($urandom_range(1, 4)), r);
    end
    rand_host = 0;
    in_valid = 1'b0; in_eof = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
